// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the IF/EX memory-port arbiter: request bus layout and requester IDs.
`ifndef MEM_REQ_ARBITER_MACROS
`define MEM_REQ_ARBITER_MACROS
`define SRAM_REQ_BUS_LEN 71
`define ARB_ID_INST 1'b0
`define ARB_ID_DATA 1'b1
`define SRAM_REQ_WR    70
`define SRAM_REQ_SIZE  69:68
`define SRAM_REQ_WSTRB 67:64
`define SRAM_REQ_ADDR  63:32
`define SRAM_REQ_WDATA 31:0
`endif

package mem_req_arbiter_pkg;
  localparam int SRAM_REQ_BUS_LEN = `SRAM_REQ_BUS_LEN;

  typedef enum logic {
    ARB_ID_INST = `ARB_ID_INST,
    ARB_ID_DATA = `ARB_ID_DATA
  } arb_id_e;
endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// In-order record of which requester owns each accepted-but-unreturned memory request.
module arb_id_fifo #(
  parameter int OUTST = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_din,
  input  logic                   i_pop,
  output logic                   o_head,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(OUTST):0] o_count
);
  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CW = $clog2(OUTST) + 1;

  logic [OUTST-1:0] r_mem;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(OUTST));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  // A push into a full FIFO is only safe when a pop frees the slot in the same cycle.
  assign w_push  = i_push & (~o_full | i_pop);
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= (r_wr_ptr == PW'(OUTST - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(OUTST - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like port between fetch and data requesters; data has priority,
// fetch is forced after MAX_DATA_RUN back-to-back data grants, responses routed in order.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int OUTST        = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inst_req,
  input  logic [SRAM_REQ_BUS_LEN-1:0] inst_req_bus,
  output logic                        inst_addr_ok,
  output logic                        inst_data_ok,
  output logic [31:0]                 inst_rdata,
  input  logic                        data_req,
  input  logic [SRAM_REQ_BUS_LEN-1:0] data_req_bus,
  output logic                        data_addr_ok,
  output logic                        data_data_ok,
  output logic [31:0]                 data_rdata,
  output logic                        mem_req,
  output logic [SRAM_REQ_BUS_LEN-1:0] mem_req_bus,
  input  logic                        mem_addr_ok,
  input  logic                        mem_data_ok,
  input  logic [31:0]                 mem_rdata,
  output logic                        busy
);
  localparam int RW = $clog2(MAX_DATA_RUN + 1);
  localparam int CW = $clog2(OUTST) + 1;

  logic            r_lock_valid;
  arb_id_e         r_lock_id;
  logic [RW-1:0]   r_data_run;
  logic            w_gnt_valid;
  arb_id_e         w_gnt_id;
  logic            w_accept;
  logic            w_resp;
  logic            w_head;
  logic            w_empty;
  logic            w_full;
  logic [CW-1:0]   w_count;

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = ARB_ID_DATA;
    if (!w_full) begin
      // A stalled grant stays with its owner until the handshake completes.
      if (r_lock_valid) begin
        w_gnt_id    = r_lock_id;
        w_gnt_valid = (r_lock_id == ARB_ID_DATA) ? data_req : inst_req;
      end else if (inst_req && data_req) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = (r_data_run == RW'(MAX_DATA_RUN)) ? ARB_ID_INST : ARB_ID_DATA;
      end else if (data_req) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = ARB_ID_DATA;
      end else if (inst_req) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = ARB_ID_INST;
      end
    end
  end

  assign mem_req      = w_gnt_valid;
  assign mem_req_bus  = (w_gnt_id == ARB_ID_DATA) ? data_req_bus : inst_req_bus;
  assign w_accept     = mem_req & mem_addr_ok;
  assign inst_addr_ok = w_accept & (w_gnt_id == ARB_ID_INST);
  assign data_addr_ok = w_accept & (w_gnt_id == ARB_ID_DATA);

  // Responses arriving with nothing outstanding are silently dropped.
  assign w_resp       = mem_data_ok & ~w_empty;
  assign data_data_ok = w_resp & (w_head == ARB_ID_DATA);
  assign inst_data_ok = w_resp & (w_head == ARB_ID_INST);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign busy         = (w_count != '0) | mem_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_valid <= 1'b0;
      r_lock_id    <= ARB_ID_INST;
      r_data_run   <= '0;
    end else begin
      if (mem_req && !mem_addr_ok) begin
        r_lock_valid <= 1'b1;
        r_lock_id    <= w_gnt_id;
      end else if (w_accept) begin
        r_lock_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_gnt_id == ARB_ID_DATA && inst_req) begin
          if (r_data_run != RW'(MAX_DATA_RUN)) r_data_run <= r_data_run + RW'(1);
        end else begin
          r_data_run <= '0;
        end
      end
    end
  end

  arb_id_fifo #(.OUTST(OUTST)) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_accept),
    .i_din   (w_gnt_id == ARB_ID_DATA),
    .i_pop   (w_resp),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench: per-cycle vector table plus starvation and reset-mid-flight sequences.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req;
  logic [70:0] inst_req_bus, data_req_bus, mem_req_bus;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_rdata;
  logic        mem_req, mem_addr_ok, mem_data_ok, busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.OUTST(2), .MAX_DATA_RUN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_req_bus (inst_req_bus),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_req_bus (data_req_bus),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_req_bus  (mem_req_bus),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  typedef struct {
    logic        ireq, dreq, aok, dok;
    logic [31:0] iaddr, daddr, rdata;
    logic [5:0]  exp;  // {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy}
    logic        sel;  // expected granted side when mem_req: 0=inst, 1=data
  } vec_t;

  vec_t vecs[$];

  function automatic logic [70:0] ibus(input logic [31:0] a);
    return {1'b0, 2'b10, 4'b1111, a, 32'h0};
  endfunction

  function automatic logic [70:0] dbus(input logic [31:0] a);
    return {1'b1, 2'b10, 4'b0011, a, a ^ 32'hDEAD0000};
  endfunction

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic ireq, input logic dreq, input logic aok, input logic dok,
                     input logic [31:0] iaddr, input logic [31:0] daddr, input logic [31:0] rdata,
                     input logic [5:0] exp, input logic sel);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok;
    v.iaddr = iaddr; v.daddr = daddr; v.rdata = rdata; v.exp = exp; v.sel = sel;
    vecs.push_back(v);
  endtask

  initial begin
    logic [9:0] pat;
    reset = 1'b1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    inst_req_bus = ibus(32'h1C000000); data_req_bus = dbus(32'h100);
    mem_rdata = 32'h5A5A5A5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 71'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy}), 71'(0));
    chk("reset_rdata", 71'({inst_rdata, data_rdata}), 71'({32'h5A5A5A5A, 32'h5A5A5A5A}));
    reset = 1'b0;
    @(posedge clk); #1;

    // single fetch
    add(1,0,1,0, 32'h1C000000, 32'h100, 32'h0,        6'b110001, 0);
    add(0,0,0,0, 32'h1C000000, 32'h100, 32'h0,        6'b000001, 0);
    add(0,0,0,0, 32'h1C000000, 32'h100, 32'h0,        6'b000001, 0);
    add(0,0,0,1, 32'h1C000000, 32'h100, 32'h02800000, 6'b000101, 0);
    add(0,0,0,0, 32'h1C000000, 32'h100, 32'h0,        6'b000000, 0);
    // both requesting: data first, then inst
    add(1,1,1,0, 32'h1C000000, 32'h104, 32'h0,        6'b101001, 1);
    add(1,0,1,0, 32'h1C000004, 32'h104, 32'h0,        6'b110001, 0);
    add(0,0,0,1, 32'h1C000004, 32'h104, 32'hAAAA0001, 6'b000011, 0);
    add(0,0,0,1, 32'h1C000004, 32'h104, 32'hBBBB0002, 6'b000101, 0);
    add(0,0,0,0, 32'h1C000004, 32'h104, 32'h0,        6'b000000, 0);
    // inst locked while addr_ok low, data arrives later
    add(1,0,0,0, 32'h1C000008, 32'h108, 32'h0,        6'b100001, 0);
    add(1,1,0,0, 32'h1C000008, 32'h108, 32'h0,        6'b100001, 0);
    add(1,1,0,0, 32'h1C000008, 32'h108, 32'h0,        6'b100001, 0);
    add(1,1,1,0, 32'h1C000008, 32'h108, 32'h0,        6'b110001, 0);
    add(0,1,1,0, 32'h1C000008, 32'h108, 32'h0,        6'b101001, 1);
    add(0,0,0,1, 32'h1C000008, 32'h108, 32'h11111111, 6'b000101, 0);
    add(0,0,0,1, 32'h1C000008, 32'h108, 32'h22222222, 6'b000011, 0);
    add(0,0,0,0, 32'h1C000008, 32'h108, 32'h0,        6'b000000, 0);
    // ordering and full stall, then push+pop at count 1, then spurious response
    add(0,1,1,0, 32'h1C000004, 32'h100, 32'h0,        6'b101001, 1);
    add(1,0,1,0, 32'h1C000004, 32'h100, 32'h0,        6'b110001, 0);
    add(0,1,1,0, 32'h1C000004, 32'h200, 32'h0,        6'b000001, 1);
    add(0,1,1,1, 32'h1C000004, 32'h200, 32'hA5A50001, 6'b000011, 1);
    add(0,1,1,0, 32'h1C000004, 32'h200, 32'h0,        6'b101001, 1);
    add(0,0,0,1, 32'h1C000004, 32'h200, 32'hB4B40002, 6'b000101, 0);
    add(1,0,1,1, 32'h1C00000C, 32'h200, 32'hC3C30003, 6'b110011, 0);
    add(0,0,0,1, 32'h1C00000C, 32'h200, 32'hD2D20004, 6'b000101, 0);
    add(0,0,0,1, 32'h1C00000C, 32'h200, 32'hE1E10005, 6'b000000, 0);
    add(0,0,0,0, 32'h1C00000C, 32'h200, 32'h0,        6'b000000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      inst_req = vecs[i].ireq; data_req = vecs[i].dreq;
      mem_addr_ok = vecs[i].aok; mem_data_ok = vecs[i].dok; mem_rdata = vecs[i].rdata;
      inst_req_bus = ibus(vecs[i].iaddr); data_req_bus = dbus(vecs[i].daddr);
      @(negedge clk);
      $display("vec %0d: mem_req=%0b iaok=%0b daok=%0b idok=%0b ddok=%0b busy=%0b",
               i, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy);
      chk($sformatf("vec%0d_ctl", i),
          71'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy}), 71'(vecs[i].exp));
      if (vecs[i].exp[5])
        chk($sformatf("vec%0d_bus", i), mem_req_bus,
            vecs[i].sel ? dbus(vecs[i].daddr) : ibus(vecs[i].iaddr));
      if (vecs[i].exp[2]) chk($sformatf("vec%0d_irdata", i), 71'(inst_rdata), 71'(vecs[i].rdata));
      if (vecs[i].exp[1]) chk($sformatf("vec%0d_drdata", i), 71'(data_rdata), 71'(vecs[i].rdata));
      @(posedge clk); #1;
    end

    // starvation guard: D,D,D,D,I,D,D,D,D,I (bit set = data)
    pat = 10'b0111101111;
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    inst_req_bus = ibus(32'h1C000010); data_req_bus = dbus(32'h300);
    for (int i = 0; i < 10; i++) begin
      mem_rdata = 32'h77000000 + 32'(i);
      @(negedge clk);
      $display("starve %0d: mem_req=%0b daok=%0b iaok=%0b idok=%0b ddok=%0b",
               i, mem_req, data_addr_ok, inst_addr_ok, inst_data_ok, data_data_ok);
      chk($sformatf("starve%0d_gnt", i), 71'({mem_req, data_addr_ok, inst_addr_ok}),
          71'({1'b1, pat[i], ~pat[i]}));
      if (i == 0) chk("starve0_resp", 71'({inst_data_ok, data_data_ok}), 71'(0));
      else chk($sformatf("starve%0d_resp", i), 71'({inst_data_ok, data_data_ok}),
               71'({~pat[i-1], pat[i-1]}));
      @(posedge clk); #1;
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    @(negedge clk);
    chk("starve_drain_idok", 71'({inst_data_ok, data_data_ok}), 71'(2'b10));
    @(posedge clk); #1;
    mem_data_ok = 0;
    @(negedge clk);
    chk("starve_idle_busy", 71'(busy), 71'(0));
    @(posedge clk); #1;

    // reset mid-flight
    inst_req = 1; mem_addr_ok = 1; inst_req_bus = ibus(32'h1C000020);
    @(negedge clk);
    chk("rst_pre_accept", 71'(inst_addr_ok), 71'(1));
    @(posedge clk); #1;
    inst_req = 0; mem_addr_ok = 0;
    @(negedge clk);
    chk("rst_pre_busy", 71'(busy), 71'(1));
    #1 reset = 1;
    #1;
    chk("rst_async_clear", 71'({mem_req, busy}), 71'(0));
    @(posedge clk);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    mem_data_ok = 1; mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    $display("post-reset data_ok: idok=%0b ddok=%0b busy=%0b mem_req=%0b",
             inst_data_ok, data_data_ok, busy, mem_req);
    chk("rst_dropped_resp", 71'({inst_data_ok, data_data_ok, busy, mem_req}), 71'(0));
    @(posedge clk); #1;
    mem_data_ok = 0; inst_req = 1; mem_addr_ok = 1;
    @(negedge clk);
    chk("rst_new_req", 71'({mem_req, inst_addr_ok}), 71'(2'b11));
    @(posedge clk); #1;
    inst_req = 0; mem_addr_ok = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Shares one sram-like memory port between the IF instruction-fetch requester and the EX data-access requester. EX drives the data_sram request fields on the data side.
Tracks outstanding accepted requests in order and routes each data_ok/rdata back to the requester that issued it.
Sits between the pipeline stages and the memory-side bridge.
Provides data-side priority with a bounded-starvation guard for fetch.

Parameters:
OUTST, 2, maximum accepted-but-unreturned requests (power of two, 1..8)
MAX_DATA_RUN, 4, consecutive data grants allowed while inst_req waits before inst is forced

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
inst_req  in  1  fetch request valid
inst_req_bus  in  `SRAM_REQ_BUS_LEN  {wr, size[1:0], wstrb[3:0], addr[31:0], wdata[31:0]} (71 bits)
inst_addr_ok  out  1  fetch request accepted
inst_data_ok  out  1  fetch response valid
inst_rdata  out  32  fetch response data
data_req  in  1  data request valid
data_req_bus  in  `SRAM_REQ_BUS_LEN  same layout as inst_req_bus
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data response data
mem_req  out  1  downstream request valid
mem_req_bus  out  `SRAM_REQ_BUS_LEN  selected request fields
mem_addr_ok  in  1  downstream accept
mem_data_ok  in  1  downstream response (returned in acceptance order)
mem_rdata  in  32  downstream response data
busy  out  1  outstanding count != 0 or mem_req

Behaviour:
- Reset: clock and reset are clk and reset; one clock; reset is asynchronous and active-high. It clears the ID FIFO (empty), lock_valid=0, lock_id=0 and data_run=0.
- Reset output values: mem_req=0, all *_addr_ok=0, all *_data_ok=0, busy=0. The rdata outputs equal mem_rdata.
- Reset mid-transaction: all outstanding state is discarded. Later mem_data_ok with an empty FIFO is dropped.
- Grant (combinational, no new grant when count==OUTST):
  - lock_valid: grant=lock_id.
  - Otherwise, both requesting: grant=INST if data_run==MAX_DATA_RUN, else DATA.
  - Otherwise: grant goes to the single requester.
- mem_req = grant valid. mem_req_bus = bus of the granted side. Zero-latency pass-through.
- X_addr_ok = mem_addr_ok & mem_req & grant==X. Only the granted side ever sees addr_ok.
- Lock: if mem_req & ~mem_addr_ok, the next cycle has lock_valid=1 and lock_id=grant. The lock clears on the accepted handshake. A requester must hold req and bus stable until addr_ok; a higher-priority arrival never preempts a locked grant.
- Accept (mem_req & mem_addr_ok): push the grant ID (0=INST, 1=DATA) into the FIFO.
- data_run update on accept:
  - DATA accepted with inst_req high: increment, saturating at MAX_DATA_RUN.
  - INST accepted, or inst_req low: cleared to 0.
- Response (mem_data_ok & FIFO non-empty): pop. head==DATA drives data_data_ok=1, else inst_data_ok=1. Exactly one response per cycle. mem_data_ok with an empty FIFO: dropped, no pop, no *_data_ok.
- Simultaneous accept and response in one cycle: push and pop both happen and count is unchanged. Legal even when count==OUTST-1.
- count==OUTST: mem_req forced 0 (lock state retained). Grant resumes the cycle after a pop.
- FIFO pointers are log2(OUTST) bits and wrap modulo OUTST. The count is log2(OUTST)+1 bits.

Decomposition:
- macro.vh: `SRAM_REQ_BUS_LEN (71), `ARB_ID_INST (1'b0), `ARB_ID_DATA (1'b1), plus field-slice macros for the wr/size/wstrb/addr/wdata positions.
- Sub-module arb_id_fifo: 1-bit-wide synchronous FIFO, depth OUTST, with push, pop, head, empty, full and count outputs. Asynchronous reset.

Test Plan:
- Reset mid-flight: accept INST, assert reset, then pulse mem_data_ok -> no *_data_ok, busy=0, mem_req=0 until a new req.
- Single fetch: inst_req=1, addr 0x1C000000, addr_ok the same cycle. data_ok 3 cycles later with rdata 0x02800000 -> inst_addr_ok=1 once, inst_data_ok=1 once with that rdata, busy falls the next cycle.
- Priority and lock:
  - Both requesting in the same cycle, mem_addr_ok=1 -> DATA granted first, INST next.
  - INST granted with addr_ok held low 3 cycles, data_req rising in cycle 2 -> mem_req_bus stays the inst bus until accept.
- Ordering with OUTST=2:
  - Accept DATA(0x100), then INST(0x1C000004); responses rdata A then B -> data_rdata=A, inst_rdata=B.
  - A third req waits with mem_req=0 until the first data_ok.
- Starvation guard, MAX_DATA_RUN=4: data_req and inst_req held high, addr_ok always 1, data_ok every cycle -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Edge cases:
  - Push and pop in the same cycle at count=1 -> count stays 1, correct routing.
  - Spurious mem_data_ok at count=0 -> ignored.
